// File: rtl/reset_sequencer_pkg.sv
// Shared types for the board reset sequencer: FSM state and reset-cause encodings.
// Both encodings are visible on status ports, so their values are fixed here.
package reset_sequencer_pkg;

    localparam logic [1:0] CAUSE_ENC_LOCK = 2'd0;
    localparam logic [1:0] CAUSE_ENC_SW   = 2'd1;
    localparam logic [1:0] CAUSE_ENC_BTN  = 2'd2;

    localparam logic [7:0] RST_COUNT_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK    = 2'd0,
        ST_HOLD         = 2'd1,
        ST_RUN          = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_LOCK = CAUSE_ENC_LOCK,
        CAUSE_SW   = CAUSE_ENC_SW,
        CAUSE_BTN  = CAUSE_ENC_BTN
    } cause_e;

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// Two-flop synchronizer plus debounce counter for the raw user button.
// The debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_db
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_btn_meta;
    logic          r_btn_sync;
    logic          r_btn_db;
    logic [CW-1:0] r_db_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_db   <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_meta <= btn_i;
            r_btn_sync <= r_btn_meta;
            if (r_btn_sync == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_db <= ~r_btn_db;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CW'(1);
            end
        end
    end

    assign btn_db = r_btn_db;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: waits for PLL lock, stretches core reset, and re-enters
// reset on lock loss, software request, or a long button press.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES       = 16,
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter int LONG_PRESS_CYCLES = 4194304
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       btn_i,
    input  logic       sw_rst_req_i,
    output logic       rst_core_o,
    output logic       btn_db_o,
    output logic [1:0] state_o,
    output logic [1:0] cause_o,
    output logic [7:0] rst_count_o
);

    localparam int            HW        = $clog2(HOLD_CYCLES) + 1;
    localparam int            LW        = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LP_LIMIT  = LW'(LONG_PRESS_CYCLES);

    logic          r_lock_meta;
    logic          r_lock_sync;
    logic          w_btn_db;
    state_e        r_state;
    state_e        w_next_state;
    cause_e        r_cause;
    cause_e        w_next_cause;
    logic          w_leave_run;
    logic          r_rst_core;
    logic [HW-1:0] r_hold_cnt;
    logic [LW-1:0] r_lp_cnt;
    logic [7:0]    r_rst_count;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (btn_i),
        .btn_db(w_btn_db)
    );

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (r_lock_sync) w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (!r_lock_sync)                w_next_state = ST_WAIT_LOCK;
                else if (r_hold_cnt == HOLD_LAST) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (!r_lock_sync) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cause = CAUSE_LOCK;
                end else if (r_lp_cnt == LP_LIMIT) begin
                    w_next_state = ST_WAIT_RELEASE;
                    w_next_cause = CAUSE_BTN;
                end else if (sw_rst_req_i) begin
                    w_next_state = ST_HOLD;
                    w_next_cause = CAUSE_SW;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!r_lock_sync)  w_next_state = ST_WAIT_LOCK;
                else if (!w_btn_db) w_next_state = ST_HOLD;
            end
            default: w_next_state = ST_WAIT_LOCK;
        endcase
    end

    assign w_leave_run = (r_state == ST_RUN) && (w_next_state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_state     <= ST_WAIT_LOCK;
            r_cause     <= CAUSE_LOCK;
            r_rst_core  <= 1'b1;
            r_hold_cnt  <= '0;
            r_lp_cnt    <= '0;
            r_rst_count <= '0;
        end else begin
            r_lock_meta <= pll_locked_i;
            r_lock_sync <= r_lock_meta;
            r_state     <= w_next_state;
            r_cause     <= w_next_cause;
            // Loaded from the next state so reset release lines up with the RUN state edge.
            r_rst_core  <= (w_next_state != ST_RUN);

            if (r_state == ST_HOLD && w_next_state == ST_HOLD) r_hold_cnt <= r_hold_cnt + HW'(1);
            else                                                r_hold_cnt <= '0;

            if (r_state == ST_RUN && w_next_state == ST_RUN && w_btn_db) begin
                if (r_lp_cnt != LP_LIMIT) r_lp_cnt <= r_lp_cnt + LW'(1);
            end else begin
                r_lp_cnt <= '0;
            end

            if (w_leave_run && r_rst_count != RST_COUNT_MAX) r_rst_count <= r_rst_count + 8'd1;
        end
    end

    assign rst_core_o  = r_rst_core;
    assign btn_db_o    = w_btn_db;
    assign state_o     = r_state;
    assign cause_o     = r_cause;
    assign rst_count_o = r_rst_count;

endmodule
